// File: rtl/r5p_wb_arb_pkg.sv
// Shared definitions for the R5P GPR write-port arbiter.
// - wb_src_et   : identifies the source owning the write port
// - STARVE_DEF  : default number of cycles an LSU/MDU request may lose to
//                 the pipeline before it is forced through
package r5p_wb_arb_pkg;

  typedef enum logic [1:0] {
    WB_PIP = 2'd0,
    WB_LSU = 2'd1,
    WB_MDU = 2'd2
  } wb_src_et;

  localparam int unsigned STARVE_DEF = 4;

endpackage

// File: rtl/r5p_wb_arb_if.sv
// Write-back request bundle between the result sources and the arbiter.
// Each of the three sources (pipeline, LSU, MDU) has a vld/rdy handshake
// with a destination register address and data word.
// - master : result sources (drive vld/adr/dat, receive rdy)
// - slave  : arbiter (receives vld/adr/dat, drives rdy)
interface r5p_wb_arb_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            pip_vld;
  logic            pip_rdy;
  logic [4:0]      pip_adr;
  logic [XLEN-1:0] pip_dat;

  logic            lsu_vld;
  logic            lsu_rdy;
  logic [4:0]      lsu_adr;
  logic [XLEN-1:0] lsu_dat;

  logic            mdu_vld;
  logic            mdu_rdy;
  logic [4:0]      mdu_adr;
  logic [XLEN-1:0] mdu_dat;

  modport master (
    output pip_vld, pip_adr, pip_dat,
    output lsu_vld, lsu_adr, lsu_dat,
    output mdu_vld, mdu_adr, mdu_dat,
    input  pip_rdy, lsu_rdy, mdu_rdy
  );

  modport slave (
    input  pip_vld, pip_adr, pip_dat,
    input  lsu_vld, lsu_adr, lsu_dat,
    input  mdu_vld, mdu_adr, mdu_dat,
    output pip_rdy, lsu_rdy, mdu_rdy
  );

endinterface

// File: rtl/r5p_wb_scoreboard.sv
// Pending-destination scoreboard for long-latency ops (loads, MDU).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   set_ena, set_adr         long-latency op issued, its rd
//   clr_ena, clr_adr         LSU/MDU result written back, its rd
//   dec_rs1/rs2/rd(+_ena)    decode-stage register uses
//   hzd                      decode must stall (combinational)
module r5p_wb_scoreboard (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_ena,
  input  logic [4:0] set_adr,
  input  logic       clr_ena,
  input  logic [4:0] clr_adr,
  input  logic [4:0] dec_rs1,
  input  logic [4:0] dec_rs2,
  input  logic [4:0] dec_rd,
  input  logic       dec_rs1_ena,
  input  logic       dec_rs2_ena,
  input  logic       dec_rd_ena,
  output logic       hzd
);

  logic [31:0] pending;
  logic [31:0] pending_nxt;

  // Clear first, then set, so a same-cycle issue to the register being
  // retired keeps it pending. x0 is never tracked.
  always_comb begin
    pending_nxt = pending;
    if (clr_ena)
      pending_nxt[clr_adr] = 1'b0;
    if (set_ena && (set_adr != 5'd0))
      pending_nxt[set_adr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= '0;
    else
      pending <= pending_nxt;
  end

  // Registered state only: a result granted this cycle still stalls decode.
  assign hzd = (dec_rs1_ena & pending[dec_rs1])
             | (dec_rs2_ena & pending[dec_rs2])
             | (dec_rd_ena  & pending[dec_rd]);

endmodule

// File: rtl/r5p_wb_arb.sv
// GPR write-port arbiter for the R5P core. Shares the single register-file
// write port between the pipeline, LSU load return and MDU result, and
// tracks outstanding long-latency destinations for decode hazard detection.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   bus (slave)           pip/lsu/mdu vld, rdy, adr, dat handshakes
//   iss_ena, iss_adr      long-latency op issued, its rd
//   dec_rs1/rs2/rd(+_ena) decode register uses
//   hzd                   decode stall (combinational)
//   wen, adr, dat         registered GPR write port
module r5p_wb_arb
  import r5p_wb_arb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STARVE = STARVE_DEF
) (
  input  logic            clk,
  input  logic            rst,
  r5p_wb_arb_if.slave     bus,
  input  logic            iss_ena,
  input  logic [4:0]      iss_adr,
  input  logic [4:0]      dec_rs1,
  input  logic [4:0]      dec_rs2,
  input  logic [4:0]      dec_rd,
  input  logic            dec_rs1_ena,
  input  logic            dec_rs2_ena,
  input  logic            dec_rd_ena,
  output logic            hzd,
  output logic            wen,
  output logic [4:0]      adr,
  output logic [XLEN-1:0] dat
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE);

  wb_src_et        ptr;
  wb_src_et        rr_src;
  wb_src_et        gnt_src;
  logic            gnt;
  logic            lr_any;
  logic            lr_gnt;
  logic            forced;
  logic [3:0]      cnt;
  logic [4:0]      gnt_adr;
  logic [XLEN-1:0] gnt_dat;

  // Arbitration: pipeline first unless the starvation limit is reached,
  // in which case the LSU/MDU round-robin winner takes the slot.
  always_comb begin
    lr_any  = bus.lsu_vld | bus.mdu_vld;
    if (bus.lsu_vld && bus.mdu_vld)
      rr_src = ptr;
    else if (bus.lsu_vld)
      rr_src = WB_LSU;
    else
      rr_src = WB_MDU;
    forced  = lr_any && (cnt == STARVE_LIM);
    gnt     = 1'b0;
    gnt_src = WB_PIP;
    if (!rst) begin
      if (bus.pip_vld && !forced) begin
        gnt     = 1'b1;
        gnt_src = WB_PIP;
      end else if (lr_any) begin
        gnt     = 1'b1;
        gnt_src = rr_src;
      end
    end
    lr_gnt = gnt && (gnt_src != WB_PIP);
    case (gnt_src)
      WB_LSU: begin
        gnt_adr = bus.lsu_adr;
        gnt_dat = bus.lsu_dat;
      end
      WB_MDU: begin
        gnt_adr = bus.mdu_adr;
        gnt_dat = bus.mdu_dat;
      end
      default: begin
        gnt_adr = bus.pip_adr;
        gnt_dat = bus.pip_dat;
      end
    endcase
  end

  assign bus.pip_rdy = gnt && (gnt_src == WB_PIP);
  assign bus.lsu_rdy = gnt && (gnt_src == WB_LSU);
  assign bus.mdu_rdy = gnt && (gnt_src == WB_MDU);

  // Write-port register stage: grant in cycle N appears on wen/adr/dat in N+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ptr <= WB_LSU;
      wen <= 1'b0;
      adr <= '0;
      dat <= '0;
    end else begin
      if (lr_gnt || !lr_any)
        cnt <= '0;
      else if (cnt != STARVE_LIM)
        cnt <= cnt + 4'd1;
      // Point at the source that was not just served.
      if (lr_gnt)
        ptr <= (gnt_src == WB_LSU) ? WB_MDU : WB_LSU;
      wen <= gnt && (gnt_adr != 5'd0);
      if (gnt) begin
        adr <= gnt_adr;
        dat <= gnt_dat;
      end
    end
  end

  r5p_wb_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_ena     (iss_ena),
    .set_adr     (iss_adr),
    .clr_ena     (lr_gnt),
    .clr_adr     (gnt_adr),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rd      (dec_rd),
    .dec_rs1_ena (dec_rs1_ena),
    .dec_rs2_ena (dec_rs2_ena),
    .dec_rd_ena  (dec_rd_ena),
    .hzd         (hzd)
  );

endmodule

// File: doc/r5p_wb_arb.md
# r5p_wb_arb

GPR write-port arbiter and long-latency scoreboard for the R5P core. It shares the single register-file write port between three sources: the in-order pipeline write back (ALU/PC increment/upper immediate), the LSU load return, and the MDU (mul/div/rem) result. It tracks destination registers of outstanding loads and MDU operations and flags RAW/WAW hazards to the decode stage. The block sits between the execute-stage result sources and the GPR file.

## Interface
- XLEN, 32, data width
- STARVE, 4, cycles a waiting LSU/MDU request may lose to the pipeline before it is forced through (1..15)
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- pip_vld / pip_rdy  input/output  1  pipeline write-back request / grant
- pip_adr, pip_dat  input  5, XLEN  pipeline rd and data
- lsu_vld / lsu_rdy  input/output  1  load-return request / grant
- lsu_adr, lsu_dat  input  5, XLEN  load rd and data
- mdu_vld / mdu_rdy  input/output  1  MDU result request / grant
- mdu_adr, mdu_dat  input  5, XLEN  MDU rd and data
- iss_ena  input  1  long-latency op (load or MDU) issued this cycle
- iss_adr  input  5  its rd
- dec_rs1, dec_rs2, dec_rd  input  5  decode-stage register addresses
- dec_rs1_ena, dec_rs2_ena, dec_rd_ena  input  1  corresponding use enables
- hzd  output  1  decode must stall (combinational)
- wen  output  1  GPR write enable (registered)
- adr  output  5  GPR write address (registered)
- dat  output  XLEN  GPR write data (registered)

## Operation
- The arbiter grants at most one source per cycle. A transfer occurs when vld and rdy are both high.
- Priority: the pipeline wins by default. LSU and MDU share the remaining slot round-robin: a pointer toggles to the other source after each LSU/MDU grant. On reset, the pointer favours the LSU.
- Starvation counter: increments each cycle an LSU or MDU request is pending but not granted. When it reaches STARVE, the round-robin winner takes precedence over the pipeline for that cycle. The counter clears on any LSU/MDU grant, or when no LSU/MDU request is pending.
- A source's rdy does not depend on that source's own vld beyond the arbitration above. Requesters hold vld, adr and dat stable until granted.
- The granted source's adr/dat are registered to adr/dat. wen = grant & (adr != 0). A grant to x0 completes the handshake but does not write.
- Scoreboard: 32-bit pending vector.
  - iss_ena sets pending[iss_adr], except when iss_adr is 0.
  - An LSU or MDU grant clears pending[granted adr]. Pipeline grants never touch the scoreboard.
  - If a set and a clear hit the same register in the same cycle, the set wins.
- hzd = (dec_rs1_ena & pending[dec_rs1]) | (dec_rs2_ena & pending[dec_rs2]) | (dec_rd_ena & pending[dec_rd]). It uses registered pending only; there is no bypass from same-cycle grants.
- Reset values: wen=0, adr=0, dat=0, pending=0, starvation counter=0, pointer=LSU. During reset all rdy outputs are 0.
- Asserting rst mid-operation drops all pending entries. Upstream units are reset in the same domain and reissue nothing.

## Timing
- Arbitration is combinational: rdy in cycle N, wen/adr/dat valid in N+1 for exactly one cycle.
- The scoreboard updates at the edge ending cycle N. hzd reflects a cleared entry from N+1 and a newly issued entry from N+1.
- A pipeline request is blocked for at most one cycle per forced LSU/MDU grant. An LSU/MDU request waits at most STARVE+1 cycles.
- Back-to-back grants: one write per cycle, no bubble.

## Structure
- Shared package riscv_isa_pkg, or the core package, holds:
  - wb_src_et enum: WB_PIP, WB_LSU, WB_MDU.
  - Default STARVE localparam.
- Sub-module r5p_wb_scoreboard contains the pending vector, set/clear logic and hazard compare. The top module keeps the arbiter, starvation counter and output registers.

## Test plan
- Pipeline only: pip_vld with adr 5, dat 0x1234 -> pip_rdy same cycle; next cycle wen=1, adr=5, dat=0x1234.
- x0 write: pip_adr=0 -> pip_rdy=1, next cycle wen=0.
- Issue then complete: iss_ena with iss_adr=7, then dec_rs1=7 with ena -> hzd=1. lsu_vld with adr 7 is granted; one cycle later hzd=0 and a write to x7 appears.
- Round-robin: LSU and MDU vld continuously, pipeline idle -> grants alternate LSU, MDU, LSU starting with LSU after reset.
- Starvation: pip_vld and lsu_vld both held, STARVE=4 -> pip granted 4 cycles, LSU granted on cycle 5, counter back to 0.
- Same-cycle set/clear of x9 (iss_ena adr 9 plus MDU grant adr 9) -> pending[9] stays 1, so hzd=1 for dec_rd=9. Asserting rst mid-stream -> wen=0 and hzd=0 immediately.
